// File: rtl/ddr2_app_pkg.sv
// ---------------------------------------------------------------------------
// ddr2_app_pkg
// Shared definitions for the DDR2 application-interface responder:
//   CMD_WRITE / CMD_READ  command encodings on s_app_af_cmd
//   BURST_WORDS           app words covered by one command
//   state_t               burst-execution FSM states
// ---------------------------------------------------------------------------
package ddr2_app_pkg;

    localparam logic [2:0] CMD_WRITE   = 3'b000;
    localparam logic [2:0] CMD_READ    = 3'b001;
    localparam int         BURST_WORDS = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR0  = 3'd1,
        ST_WR1  = 3'd2,
        ST_RD0  = 3'd3,
        ST_RD1  = 3'd4
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Show-ahead synchronous FIFO: the head entry is presented on data_o while
// empty_o is low, and pop_i retires it.
// Ports:
//   clk, srst      clock, synchronous active-high reset (empties the FIFO)
//   push_i/data_i  write side; a push while full is dropped
//   pop_i          retire head entry (ignored while empty)
//   data_o         head entry
//   empty_o        no entries
//   count_o        occupancy
//   afull_o        occupancy >= DEPTH-AFULL_MARGIN
//   overflow_o     a push was attempted while full (this cycle)
// Fullness is judged on the occupancy before any same-cycle pop, so a push
// and a pop together on a full FIFO still drops the push.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       afull_o,
    output logic                       overflow_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o     = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign afull_o    = (count_q >= (AW+1)'(DEPTH - AFULL_MARGIN));
    assign overflow_o = push_i && full;

endmodule

// File: rtl/ddr2_app_responder.sv
// ---------------------------------------------------------------------------
// ddr2_app_responder
// Behavioural stand-in for a DDR2 controller user interface. Commands and
// write data are queued in two FIFOs, executed in order against an inferred
// block RAM once the init counter expires, and read bursts are returned with
// a fixed latency of RD_LATENCY cycles from the RD0 beat.
// Ports:
//   s_clk, s_rst                        clock, synchronous active-high reset
//   s_phy_init_done                     high INIT_CYCLES cycles after reset
//   s_app_af_wren/_cmd/_addr, _afull    command FIFO push side
//   s_app_wdf_wren/_data/_mask_data,
//   s_app_wdf_afull                     write-data FIFO push side
//   s_app_rd_data_valid, s_app_rd_data  read return (no backpressure)
//   s_err                               sticky: [0] FIFO overflow,
//                                               [1] illegal command
// Build option: define DDR2_APP_RESPONDER_CHECK_EN to enable the error
// detection behind s_err; otherwise s_err is tied to zero. Overflowing
// pushes are dropped and illegal commands discarded in both builds.
// ---------------------------------------------------------------------------
module ddr2_app_responder
    import ddr2_app_pkg::*;
#(
    parameter int APPDATA_WIDTH = 32,
    parameter int MASK_WIDTH    = 4,
    parameter int ADDR_BITS     = 10,
    parameter int FIFO_DEPTH    = 16,
    parameter int AFULL_MARGIN  = 4,
    parameter int RD_LATENCY    = 4,
    parameter int INIT_CYCLES   = 64
) (
    input  logic                     s_clk,
    input  logic                     s_rst,
    output logic                     s_phy_init_done,
    input  logic                     s_app_af_wren,
    input  logic [2:0]               s_app_af_cmd,
    input  logic [30:0]              s_app_af_addr,
    output logic                     s_app_af_afull,
    input  logic                     s_app_wdf_wren,
    input  logic [APPDATA_WIDTH-1:0] s_app_wdf_data,
    input  logic [MASK_WIDTH-1:0]    s_app_wdf_mask_data,
    output logic                     s_app_wdf_afull,
    output logic                     s_app_rd_data_valid,
    output logic [APPDATA_WIDTH-1:0] s_app_rd_data,
    output logic [1:0]               s_err
);

    localparam int CW         = $clog2(INIT_CYCLES + 1);
    localparam int BURST_BITS = $clog2(BURST_WORDS);
    localparam int FCW        = $clog2(FIFO_DEPTH) + 1;
    localparam int WDF_W      = APPDATA_WIDTH + MASK_WIDTH;

    // ---------------- init counter ----------------
    logic [CW-1:0] init_cnt_q;
    logic          init_done_q;

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else if (!init_done_q) begin
            init_cnt_q <= init_cnt_q + CW'(1);
            if (init_cnt_q == CW'(INIT_CYCLES - 1)) begin
                init_done_q <= 1'b1;
            end
        end
    end

    assign s_phy_init_done = init_done_q;

    // ---------------- FIFOs ----------------
    logic [33:0]        af_head;
    logic               af_empty;
    logic               af_pop;
    logic [FCW-1:0]     af_count;
    logic               af_ovf;
    logic [WDF_W-1:0]   wdf_head;
    logic               wdf_empty;
    logic               wdf_pop;
    logic [FCW-1:0]     wdf_count;
    logic               wdf_ovf;

    sync_fifo #(
        .WIDTH        (34),
        .DEPTH        (FIFO_DEPTH),
        .AFULL_MARGIN (AFULL_MARGIN)
    ) u_cmd_fifo (
        .clk        (s_clk),
        .srst       (s_rst),
        .push_i     (s_app_af_wren),
        .data_i     ({s_app_af_cmd, s_app_af_addr}),
        .pop_i      (af_pop),
        .data_o     (af_head),
        .empty_o    (af_empty),
        .count_o    (af_count),
        .afull_o    (s_app_af_afull),
        .overflow_o (af_ovf)
    );

    sync_fifo #(
        .WIDTH        (WDF_W),
        .DEPTH        (FIFO_DEPTH),
        .AFULL_MARGIN (AFULL_MARGIN)
    ) u_wdf_fifo (
        .clk        (s_clk),
        .srst       (s_rst),
        .push_i     (s_app_wdf_wren),
        .data_i     ({s_app_wdf_mask_data, s_app_wdf_data}),
        .pop_i      (wdf_pop),
        .data_o     (wdf_head),
        .empty_o    (wdf_empty),
        .count_o    (wdf_count),
        .afull_o    (s_app_wdf_afull),
        .overflow_o (wdf_ovf)
    );

    logic [2:0]               af_cmd;
    logic [30:0]              af_addr;
    logic [MASK_WIDTH-1:0]    wdf_mask;
    logic [APPDATA_WIDTH-1:0] wdf_word;

    assign af_cmd   = af_head[33:31];
    assign af_addr  = af_head[30:0];
    assign wdf_mask = wdf_head[APPDATA_WIDTH +: MASK_WIDTH];
    assign wdf_word = wdf_head[APPDATA_WIDTH-1:0];

    // ---------------- burst FSM ----------------
    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] base_q, base_d;
    logic [ADDR_BITS-1:0] ram_addr;
    logic                 ram_we;
    logic                 ram_re;
    logic                 illegal_cmd;

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        af_pop      = 1'b0;
        wdf_pop     = 1'b0;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_addr    = base_q;
        illegal_cmd = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Commands queue up during init but only execute afterwards.
                if (init_done_q && !af_empty) begin
                    af_pop = 1'b1;
                    // Bursts are aligned; bits above ADDR_BITS wrap away.
                    base_d = {af_addr[ADDR_BITS-1:BURST_BITS], {BURST_BITS{1'b0}}};
                    case (af_cmd)
                        CMD_WRITE: state_d = ST_WR0;
                        CMD_READ:  state_d = ST_RD0;
                        default:   illegal_cmd = 1'b1;
                    endcase
                end
            end
            ST_WR0: begin
                // Stall here until the burst's data word arrives.
                if (!wdf_empty) begin
                    ram_we  = 1'b1;
                    wdf_pop = 1'b1;
                    state_d = ST_WR1;
                end
            end
            ST_WR1: begin
                ram_addr = base_q | ADDR_BITS'(1);
                if (!wdf_empty) begin
                    ram_we  = 1'b1;
                    wdf_pop = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_RD0: begin
                ram_re  = 1'b1;
                state_d = ST_RD1;
            end
            ST_RD1: begin
                ram_addr = base_q | ADDR_BITS'(1);
                ram_re   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- memory and read pipe ----------------
    logic [APPDATA_WIDTH-1:0] mem [2**ADDR_BITS];
    logic [MASK_WIDTH-1:0]    byte_we;
    logic [APPDATA_WIDTH-1:0] pipe_q [RD_LATENCY];
    logic [RD_LATENCY-1:0]    vld_q;

    // A set mask bit protects that byte from being written.
    generate
        for (genvar gi = 0; gi < MASK_WIDTH; gi++) begin : g_byte_we
            assign byte_we[gi] = ram_we && !wdf_mask[gi] && !s_rst;
        end
    endgenerate

    // pipe_q[0] is the RAM output register; the rest form the delay line.
    always_ff @(posedge s_clk) begin
        for (int b = 0; b < MASK_WIDTH; b++) begin
            if (byte_we[b]) begin
                mem[ram_addr][b*8 +: 8] <= wdf_word[b*8 +: 8];
            end
        end
        if (ram_re) begin
            pipe_q[0] <= mem[ram_addr];
        end
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= ram_re;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    assign s_app_rd_data_valid = vld_q[RD_LATENCY-1];
    // Data bus idles at zero so it is clean out of reset and between bursts.
    assign s_app_rd_data = vld_q[RD_LATENCY-1] ? pipe_q[RD_LATENCY-1] : '0;

    // ---------------- error reporting ----------------
`ifdef DDR2_APP_RESPONDER_CHECK_EN
    logic [1:0] err_q;

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            err_q <= 2'b00;
        end else begin
            if (af_ovf || wdf_ovf) begin
                err_q[0] <= 1'b1;
            end
            if (illegal_cmd) begin
                err_q[1] <= 1'b1;
            end
        end
    end

    assign s_err = err_q;
`else
    logic unused_checks;
    assign unused_checks = ^{af_ovf, wdf_ovf, illegal_cmd};
    assign s_err = 2'b00;
`endif

    logic unused_bits;
    assign unused_bits = ^{af_count, wdf_count, af_addr[30:ADDR_BITS], af_addr[0]};

endmodule

// File: tb/tb_ddr2_app_responder.sv
module tb_ddr2_app_responder;
    import ddr2_app_pkg::*;

    logic        s_clk = 1'b0;
    logic        s_rst = 1'b1;
    logic        s_phy_init_done;
    logic        s_app_af_wren = 1'b0;
    logic [2:0]  s_app_af_cmd = 3'b000;
    logic [30:0] s_app_af_addr = '0;
    logic        s_app_af_afull;
    logic        s_app_wdf_wren = 1'b0;
    logic [31:0] s_app_wdf_data = '0;
    logic [3:0]  s_app_wdf_mask_data = '0;
    logic        s_app_wdf_afull;
    logic        s_app_rd_data_valid;
    logic [31:0] s_app_rd_data;
    logic [1:0]  s_err;

`ifdef DDR2_APP_RESPONDER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] model [1024];
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];

    always #5 s_clk = ~s_clk;

    ddr2_app_responder dut (
        .s_clk               (s_clk),
        .s_rst               (s_rst),
        .s_phy_init_done     (s_phy_init_done),
        .s_app_af_wren       (s_app_af_wren),
        .s_app_af_cmd        (s_app_af_cmd),
        .s_app_af_addr       (s_app_af_addr),
        .s_app_af_afull      (s_app_af_afull),
        .s_app_wdf_wren      (s_app_wdf_wren),
        .s_app_wdf_data      (s_app_wdf_data),
        .s_app_wdf_mask_data (s_app_wdf_mask_data),
        .s_app_wdf_afull     (s_app_wdf_afull),
        .s_app_rd_data_valid (s_app_rd_data_valid),
        .s_app_rd_data       (s_app_rd_data),
        .s_err               (s_err)
    );

    // Collect every returned word; tasks compare against exp_q.
    always @(negedge s_clk) begin
        if (s_app_rd_data_valid) obs_q.push_back(s_app_rd_data);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge s_clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] mask);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (!mask[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    task automatic raw_cmd(input logic [2:0] cmd, input logic [30:0] addr);
        s_app_af_wren = 1'b1;
        s_app_af_cmd  = cmd;
        s_app_af_addr = addr;
        tick();
        s_app_af_wren = 1'b0;
    endtask

    task automatic push_data(input logic [31:0] d, input logic [3:0] m);
        s_app_wdf_wren      = 1'b1;
        s_app_wdf_data      = d;
        s_app_wdf_mask_data = m;
        tick();
        s_app_wdf_wren = 1'b0;
    endtask

    task automatic cmd_write(input logic [30:0] addr, input logic [31:0] d0, input logic [3:0] m0,
                             input logic [31:0] d1, input logic [3:0] m1);
        int b;
        b = int'({addr[9:1], 1'b0});
        model[b]   = merge(model[b], d0, m0);
        model[b+1] = merge(model[b+1], d1, m1);
        raw_cmd(CMD_WRITE, addr);
    endtask

    task automatic cmd_read(input logic [30:0] addr);
        int b;
        b = int'({addr[9:1], 1'b0});
        exp_q.push_back(model[b]);
        exp_q.push_back(model[b+1]);
        raw_cmd(CMD_READ, addr);
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 400) begin
            tick();
            n++;
        end
        repeat (8) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge s_clk);
        checks++; if (s_phy_init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b want 0", s_phy_init_done); end
        checks++; if (s_app_af_afull !== 1'b0) begin errors++; $display("FAIL reset_af_afull got %b want 0", s_app_af_afull); end
        checks++; if (s_app_wdf_afull !== 1'b0) begin errors++; $display("FAIL reset_wdf_afull got %b want 0", s_app_wdf_afull); end
        checks++; if (s_app_rd_data_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", s_app_rd_data_valid); end
        checks++; if (s_app_rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h want 0", s_app_rd_data); end
        checks++; if (s_err !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", s_err); end
        $display("test_reset done");
        tick();
    endtask

    task automatic test_init();
        logic e;
        s_rst = 1'b0;
        for (int c = 0; c < 70; c++) begin
            @(negedge s_clk);
            e = (c >= 64);
            checks++;
            if (s_phy_init_done !== e) begin
                errors++;
                $display("FAIL init_done cycle %0d got %b want %b", c, s_phy_init_done, e);
            end
        end
        $display("test_init done");
        tick();
    endtask

    task automatic test_loopback();
        logic ev;
        logic [31:0] o, e;
        cmd_write(31'h10, 32'hA5A50001, 4'h0, 32'hA5A50002, 4'h0);
        push_data(32'hA5A50001, 4'h0);
        push_data(32'hA5A50002, 4'h0);
        repeat (10) tick();
        cmd_read(31'h10);
        for (int k = 0; k < 8; k++) begin
            @(negedge s_clk);
            ev = (k == 5 || k == 6);
            checks++;
            if (s_app_rd_data_valid !== ev) begin
                errors++;
                $display("FAIL loopback_valid k=%0d got %b want %b", k, s_app_rd_data_valid, ev);
            end
            if (k == 5 || k == 6) begin
                e = (k == 5) ? 32'hA5A50001 : 32'hA5A50002;
                checks++;
                if (s_app_rd_data !== e) begin
                    errors++;
                    $display("FAIL loopback_data k=%0d got %h want %h", k, s_app_rd_data, e);
                end
            end
        end
        tick();
        wait_out();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL loopback_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL loopback_sb got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        $display("test_loopback done");
    endtask

    task automatic test_mask();
        logic [31:0] o, e;
        cmd_write(31'h20, 32'hFFFFFFFF, 4'h0, 32'hFFFFFFFF, 4'h0);
        push_data(32'hFFFFFFFF, 4'h0);
        push_data(32'hFFFFFFFF, 4'h0);
        cmd_write(31'h20, 32'h12345678, 4'b0101, 32'hCAFEF00D, 4'b1110);
        push_data(32'h12345678, 4'b0101);
        push_data(32'hCAFEF00D, 4'b1110);
        cmd_read(31'h20);
        wait_out();
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL mask_count got %0d want 2", obs_q.size()); end
        if (obs_q.size() == 2) begin
            checks++; if (obs_q[0] !== 32'h12FF56FF) begin errors++; $display("FAIL mask_word0 got %h want 12ff56ff", obs_q[0]); end
            checks++; if (obs_q[1] !== 32'hFFFFFF0D) begin errors++; $display("FAIL mask_word1 got %h want ffffff0d", obs_q[1]); end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL mask_sb got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        $display("test_mask done");
    endtask

    task automatic test_stall();
        logic [31:0] o, e;
        cmd_write(31'h31, 32'hDEAD0030, 4'h0, 32'hBEEF0031, 4'h0);
        cmd_read(31'h30);
        repeat (10) tick();
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL stall_early_read got %0d words want 0", obs_q.size()); end
        push_data(32'hDEAD0030, 4'h0);
        push_data(32'hBEEF0031, 4'h0);
        wait_out();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL stall_sb got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        $display("test_stall done");
    endtask

    task automatic test_afull();
        logic ea, ed;
        logic [31:0] o, e;
        s_rst = 1'b1;
        tick(); tick();
        s_rst = 1'b0;
        for (int c = 0; c < 66; c++) begin
            if (c < 12) cmd_read_setup();
            else s_app_af_wren = 1'b0;
            @(negedge s_clk);
            ea = (c >= 12) && (c <= 64);
            ed = (c >= 64);
            checks++; if (s_app_af_afull !== ea) begin errors++; $display("FAIL afull cycle %0d got %b want %b", c, s_app_af_afull, ea); end
            checks++; if (s_phy_init_done !== ed) begin errors++; $display("FAIL afull_init cycle %0d got %b want %b", c, s_phy_init_done, ed); end
            tick();
        end
        s_app_af_wren = 1'b0;
        wait_out();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL afull_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL afull_sb got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        $display("test_afull done");
    endtask

    // Drives a read of 0x10 for the coming edge without advancing time.
    task automatic cmd_read_setup();
        s_app_af_wren = 1'b1;
        s_app_af_cmd  = CMD_READ;
        s_app_af_addr = 31'h10;
        exp_q.push_back(model[16]);
        exp_q.push_back(model[17]);
    endtask

    task automatic test_overflow();
        logic [31:0] ov [17];
        logic [1:0]  ee;
        logic [31:0] o, e;
        ee = CHK ? 2'b01 : 2'b00;
        s_rst = 1'b1;
        tick(); tick();
        s_rst = 1'b0;
        for (int c = 0; c < 17; c++) begin
            ov[c] = 32'h0B0B0000 | c;
            s_app_af_wren = 1'b1;
            s_app_af_cmd  = CMD_READ;
            s_app_af_addr = (c < 16) ? 31'h10 : 31'h20;
            if (c < 16) begin
                exp_q.push_back(model[16]);
                exp_q.push_back(model[17]);
            end
            s_app_wdf_wren      = 1'b1;
            s_app_wdf_data      = ov[c];
            s_app_wdf_mask_data = 4'h0;
            tick();
        end
        s_app_af_wren  = 1'b0;
        s_app_wdf_wren = 1'b0;
        @(negedge s_clk);
        checks++; if (s_err !== ee) begin errors++; $display("FAIL ovf_err got %b want %b", s_err, ee); end
        checks++; if (s_app_af_afull !== 1'b1) begin errors++; $display("FAIL ovf_af_afull got %b want 1", s_app_af_afull); end
        checks++; if (s_app_wdf_afull !== 1'b1) begin errors++; $display("FAIL ovf_wdf_afull got %b want 1", s_app_wdf_afull); end
        tick();
        wait_out();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_cmd_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL ovf_cmd_sb got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        checks++; if (s_err !== ee) begin errors++; $display("FAIL ovf_err_sticky got %b want %b", s_err, ee); end
        // The 16 queued data words feed these writes; the 17th was dropped.
        for (int k = 0; k < 8; k++) cmd_write(31'h40 + 31'(2*k), ov[2*k], 4'h0, ov[2*k+1], 4'h0);
        cmd_write(31'h60, 32'h60606060, 4'h0, 32'h61616161, 4'h0);
        push_data(32'h60606060, 4'h0);
        push_data(32'h61616161, 4'h0);
        for (int k = 0; k < 8; k++) cmd_read(31'h40 + 31'(2*k));
        cmd_read(31'h60);
        wait_out();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_wdf_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL ovf_wdf_sb got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        $display("test_overflow done");
    endtask

    task automatic test_illegal();
        logic [31:0] o, e;
        logic [1:0]  ee;
        ee = CHK ? 2'b11 : 2'b00;
        raw_cmd(3'b011, 31'h10);
        cmd_write(31'h50, 32'h50505050, 4'h0, 32'h51515151, 4'h0);
        push_data(32'h50505050, 4'h0);
        push_data(32'h51515151, 4'h0);
        cmd_read(31'h10);
        cmd_read(31'h50);
        wait_out();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL illegal_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL illegal_sb got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        @(negedge s_clk);
        checks++; if (s_err !== ee) begin errors++; $display("FAIL illegal_err got %b want %b", s_err, ee); end
        tick();
        s_rst = 1'b1;
        tick(); tick();
        @(negedge s_clk);
        checks++; if (s_err !== 2'b00) begin errors++; $display("FAIL err_after_reset got %b want 00", s_err); end
        checks++; if (s_phy_init_done !== 1'b0) begin errors++; $display("FAIL init_after_reset got %b want 0", s_phy_init_done); end
        tick();
        s_rst = 1'b0;
        $display("test_illegal done");
    endtask

    task automatic test_reset_abort();
        int n;
        n = 0;
        while (!s_phy_init_done && n < 100) begin
            tick();
            n++;
        end
        checks++; if (s_phy_init_done !== 1'b1) begin errors++; $display("FAIL abort_init_wait got %b want 1", s_phy_init_done); end
        raw_cmd(CMD_READ, 31'h10);
        tick(); tick();
        s_rst = 1'b1;
        tick(); tick();
        s_rst = 1'b0;
        repeat (15) tick();
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL abort_inflight got %0d words want 0", obs_q.size()); end
        obs_q.delete();
        $display("test_reset_abort done");
    endtask

    initial begin
        repeat (3) tick();
        test_reset();
        test_init();
        test_loopback();
        test_mask();
        test_stall();
        test_afull();
        test_overflow();
        test_illegal();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
